// File: rtl/spi_acl_responder.sv
// spi_acl_responder: ADXL362-style SPI slave (mode 0) with an oversampled pin interface,
// a 64-byte register map and a host-side X/Y/Z sample injection port.
module spi_acl_responder #(
    parameter logic [7:0] DEVID_AD  = 8'hAD,
    parameter logic [7:0] DEVID_MST = 8'h1D,
    parameter logic [7:0] PARTID    = 8'hF2,
    parameter logic [7:0] REVID     = 8'h01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sclk_i,
    input  logic        csn_i,
    input  logic        mosi_i,
    output logic        miso_o,
    output logic        miso_oe_o,
    input  logic        sample_valid_i,
    input  logic [11:0] sample_x_i,
    input  logic [11:0] sample_y_i,
    input  logic [11:0] sample_z_i,
    output logic        wr_strobe_o,
    output logic [5:0]  wr_addr_o,
    output logic [7:0]  wr_data_o,
    output logic        busy_o
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDATA, IGNORE} state_t;

    state_t      state, next;
    logic [2:0]  sclk_q;
    logic [1:0]  csn_q, mosi_q;
    logic [2:0]  bit_cnt;
    logic [7:0]  sr, rd_data;
    logic [5:0]  ptr, rd_addr;
    logic        wr_mode, data_ready, pend;
    logic [11:0] x, y, z, sx, sy, sz;
    logic [7:0]  regs [32];

    logic       csn, rise, fall, byte_done, load, clr, commit, set_dr, do_wr;
    logic [7:0] byte_in;

    assign csn       = csn_q[1];
    assign rise      = sclk_q[1] & ~sclk_q[2];
    assign fall      = ~sclk_q[1] & sclk_q[2];
    assign byte_done = rise && bit_cnt == 3'd7;
    assign byte_in   = {sr[6:0], mosi_q[1]};
    assign load      = byte_done && ((state == ADDR && !wr_mode) || state == RDATA);
    assign rd_addr   = state == ADDR ? byte_in[5:0] : ptr + 6'd1;
    assign clr       = load && (rd_addr inside {[6'h08:6'h0A], [6'h0E:6'h13]});
    assign commit    = state != IDLE && csn;
    assign set_dr    = (state == IDLE && sample_valid_i) || (commit && (sample_valid_i || pend));
    assign do_wr     = byte_done && state == WDATA && ptr[5];
    assign busy_o    = state != IDLE;
    assign miso_oe_o = busy_o;

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = csn ? IDLE : CMD;
            CMD:     if (byte_done) next = (byte_in == 8'h0A || byte_in == 8'h0B) ? ADDR : IGNORE;
            ADDR:    if (byte_done) next = wr_mode ? WDATA : RDATA;
            default: next = state;
        endcase
        if (csn) next = IDLE;
    end

    always_comb begin
        rd_data = 8'h00;
        if (rd_addr[5]) rd_data = regs[rd_addr[4:0]];
        else case (rd_addr[4:0])
            5'h00:   rd_data = DEVID_AD;
            5'h01:   rd_data = DEVID_MST;
            5'h02:   rd_data = PARTID;
            5'h03:   rd_data = REVID;
            5'h08:   rd_data = x[11:4];
            5'h09:   rd_data = y[11:4];
            5'h0A:   rd_data = z[11:4];
            5'h0B:   rd_data = {7'b0, data_ready};
            5'h0E:   rd_data = x[7:0];
            5'h0F:   rd_data = {{4{x[11]}}, x[11:8]};
            5'h10:   rd_data = y[7:0];
            5'h11:   rd_data = {{4{y[11]}}, y[11:8]};
            5'h12:   rd_data = z[7:0];
            5'h13:   rd_data = {{4{z[11]}}, z[11:8]};
            default: rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q  <= '0;
            csn_q   <= '1;
            mosi_q  <= '0;
            state   <= IDLE;
            bit_cnt <= '0;
            sr      <= '0;
            ptr     <= '0;
            wr_mode <= 1'b0;
            miso_o  <= 1'b0;
        end else begin
            sclk_q  <= {sclk_q[1:0], sclk_i};
            csn_q   <= {csn_q[0], csn_i};
            mosi_q  <= {mosi_q[0], mosi_i};
            state   <= next;
            bit_cnt <= state == IDLE ? 3'd0 : rise ? bit_cnt + 3'd1 : bit_cnt;
            sr      <= load ? rd_data : rise ? byte_in : sr;
            if (byte_done && state == CMD) wr_mode <= ~byte_in[0];
            if (byte_done && state == ADDR) ptr <= byte_in[5:0];
            else if (byte_done && (state == WDATA || state == RDATA)) ptr <= ptr + 6'd1;
            // bit 7 of a read byte appears on the first falling edge after the byte boundary
            miso_o  <= (state == RDATA && !csn) ? (fall ? sr[7] : miso_o) : 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
            wr_strobe_o <= 1'b0;
            wr_addr_o   <= '0;
            wr_data_o   <= '0;
        end else begin
            wr_strobe_o <= do_wr;
            if (do_wr) begin
                regs[ptr[4:0]] <= byte_in;
                wr_addr_o      <= ptr;
                wr_data_o      <= byte_in;
            end
        end
    end

    // samples arriving mid-transaction wait in the shadow until csn rises
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {x, y, z, sx, sy, sz} <= '0;
            pend       <= 1'b0;
            data_ready <= 1'b0;
        end else begin
            if (commit) begin
                if (sample_valid_i) {x, y, z} <= {sample_x_i, sample_y_i, sample_z_i};
                else if (pend) {x, y, z} <= {sx, sy, sz};
                pend <= 1'b0;
            end else if (sample_valid_i) begin
                if (state == IDLE) {x, y, z} <= {sample_x_i, sample_y_i, sample_z_i};
                else begin
                    {sx, sy, sz} <= {sample_x_i, sample_y_i, sample_z_i};
                    pend <= 1'b1;
                end
            end
            data_ready <= set_dr | (data_ready & ~clr);
        end
    end
endmodule

// File: tb/tb_spi_acl_responder.sv
// tb_spi_acl_responder: directed SPI transactions against spi_acl_responder with
// hand-computed expected bytes, strobe counts and busy/enable levels.
module tb_spi_acl_responder;
    logic        clk = 0, rst_n = 0, sclk = 0, csn = 1, mosi = 0, sample_valid = 0;
    logic [11:0] sx = 0, sy = 0, sz = 0;
    logic        miso, miso_oe, wr_strobe, busy;
    logic [5:0]  wr_addr;
    logic [7:0]  wr_data, rx;
    int          checks = 0, passes = 0, strobes = 0, s0;

    spi_acl_responder dut (
        .clk(clk), .rst_n(rst_n), .sclk_i(sclk), .csn_i(csn), .mosi_i(mosi),
        .miso_o(miso), .miso_oe_o(miso_oe), .sample_valid_i(sample_valid),
        .sample_x_i(sx), .sample_y_i(sy), .sample_z_i(sz),
        .wr_strobe_o(wr_strobe), .wr_addr_o(wr_addr), .wr_data_o(wr_data), .busy_o(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (wr_strobe) strobes++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] r);
        for (int i = 7; i >= 0; i--) begin
            mosi = tx[i];
            #80 sclk = 1;
            r[i] = miso;
            #80 sclk = 0;
        end
    endtask

    task automatic bits(input logic [7:0] tx, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            mosi = tx[i];
            #80 sclk = 1;
            #80 sclk = 0;
        end
    endtask

    task automatic start_t();
        csn = 0;
        #100;
    endtask

    task automatic stop_t();
        #80 csn = 1;
        #200;
    endtask

    task automatic rd(input logic [5:0] a, input logic [7:0] exp, input string tag);
        logic [7:0] r;
        start_t();
        xfer(8'h0B, r);
        xfer({2'b00, a}, r);
        xfer(8'h00, r);
        check(tag, r, exp);
        stop_t();
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        logic [7:0] r;
        start_t();
        xfer(8'h0A, r);
        xfer({2'b00, a}, r);
        xfer(d, r);
        stop_t();
    endtask

    task automatic burst(input logic [5:0] a, input logic [47:0] e, input string tag);
        logic [7:0] r;
        start_t();
        xfer(8'h0B, r);
        xfer({2'b00, a}, r);
        for (int i = 0; i < 6; i++) begin
            xfer(8'h00, r);
            check($sformatf("%s[%0d]", tag, i), r, e[47-8*i -: 8]);
        end
        stop_t();
    endtask

    task automatic pulse(input logic [11:0] x, input logic [11:0] y, input logic [11:0] z);
        @(negedge clk);
        {sx, sy, sz} = {x, y, z};
        sample_valid = 1;
        @(negedge clk);
        sample_valid = 0;
    endtask

    initial begin
        logic [7:0] id;
        logic [31:0] ids;
        #30;
        check("rst_miso", miso, 0);
        check("rst_oe", miso_oe, 0);
        check("rst_strobe", wr_strobe, 0);
        check("rst_addr", wr_addr, 0);
        check("rst_data", wr_data, 0);
        check("rst_busy", busy, 0);
        @(negedge clk) rst_n = 1;
        #40;

        ids = 32'hAD1DF201;
        start_t();
        xfer(8'h0B, rx);
        check("busy_cmd", busy, 1);
        check("oe_cmd", miso_oe, 1);
        xfer(8'h00, rx);
        for (int i = 0; i < 4; i++) begin
            xfer(8'h00, id);
            check($sformatf("id[%0d]", i), id, ids[31-8*i -: 8]);
            check("busy_id", busy, 1);
        end
        #80 csn = 1;
        #40;
        check("busy_end", busy, 0);
        check("oe_end", miso_oe, 0);
        check("miso_end", miso, 0);
        #160;

        s0 = strobes;
        wr(6'h2C, 8'h13);
        check("wr_cnt", strobes - s0, 1);
        check("wr_addr", wr_addr, 6'h2C);
        check("wr_data", wr_data, 8'h13);
        rd(6'h2C, 8'h13, "rd_2c");

        s0 = strobes;
        wr(6'h00, 8'h55);
        check("ro_cnt", strobes - s0, 0);
        rd(6'h00, 8'hAD, "rd_00");

        pulse(12'hF80, 12'h07F, 12'h001);
        #40;
        rd(6'h0B, 8'h01, "status_set");
        burst(6'h0E, 48'h80FF7F000100, "smp");
        rd(6'h0B, 8'h00, "status_clr");
        rd(6'h08, 8'hF8, "xh8");

        s0 = strobes;
        start_t();
        xfer(8'h0A, rx);
        xfer(8'h3F, rx);
        xfer(8'hAA, rx);
        xfer(8'hBB, rx);
        stop_t();
        check("wrap_cnt", strobes - s0, 1);
        check("wrap_addr", wr_addr, 6'h3F);
        check("wrap_data", wr_data, 8'hAA);
        rd(6'h3F, 8'hAA, "rd_3f");
        rd(6'h00, 8'hAD, "rd_00_wrap");

        wr(6'h21, 8'h5A);
        s0 = strobes;
        start_t();
        xfer(8'h0A, rx);
        xfer(8'h21, rx);
        bits(8'hFF, 5);
        stop_t();
        check("abort_cnt", strobes - s0, 0);
        rd(6'h21, 8'h5A, "rd_21");

        start_t();
        xfer(8'h0D, rx);
        xfer(8'h00, rx);
        check("bad0", rx, 0);
        xfer(8'h00, rx);
        check("bad1", rx, 0);
        check("bad_busy", busy, 1);
        stop_t();

        start_t();
        xfer(8'h0B, rx);
        xfer(8'h0E, rx);
        xfer(8'h00, rx);
        check("mid_xl", rx, 8'h80);
        pulse(12'h123, 12'h456, 12'h789);
        xfer(8'h00, rx);
        check("mid_xh", rx, 8'hFF);
        xfer(8'h00, rx);
        check("mid_yl", rx, 8'h7F);
        stop_t();
        rd(6'h0B, 8'h01, "status_commit");
        burst(6'h0E, 48'h230156048907, "new");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
